// File: rtl/video_linebuf.sv
// video_linebuf: rotating set of NBUF line buffers between a renderer
// (write side) and a display (read-and-clear side). After reset an
// internal sweep zeroes every entry before normal operation begins.
module video_linebuf #(
    parameter int AW       = 9,
    parameter int DW       = 8,
    parameter int NBUF     = 2,
    parameter int TRANSP   = 1,
    parameter int LINE_LEN = 360
) (
    input  logic          clk,
    input  logic          res,
    input  logic          line_start,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_we,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_stb,
    output logic [DW-1:0] rd_data,
    output logic          init_busy,
    output logic          wr_ovf,
    output logic [1:0]    wr_sel
);

    // Buffer-select bits actually needed to address NBUF buffers.
    localparam int SW    = (NBUF > 2) ? 2 : 1;
    localparam int IW    = AW + SW;
    localparam int DEPTH = NBUF * (2 ** AW);

    localparam logic [AW+1:0] CNT_LAST = (AW+2)'(DEPTH - 1);
    localparam logic [AW:0]   LLEN     = (AW+1)'(LINE_LEN);
    localparam logic [1:0]    SEL_LAST = 2'(NBUF - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [DW-1:0] mem [0:DEPTH-1];

    logic [0:0]    state_q, state_d;
    logic [AW+1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] rd_data_q;

    logic [1:0] rd_sel;
    logic       run;
    logic       in_range;
    logic       transp;
    logic       wr_ok;
    logic       rd_ok;

    // Next buffer index in the rotation, wrapping NBUF-1 -> 0.
    function automatic logic [1:0] sel_inc(input logic [1:0] s);
        return (s == SEL_LAST) ? 2'd0 : s + 2'd1;
    endfunction

    // Flat memory index: buffer number above the pixel address.
    function automatic logic [IW-1:0] idx(input logic [1:0] s, input logic [AW-1:0] a);
        logic [AW+1:0] full;
        full = {s, a};
        return full[IW-1:0];
    endfunction

    assign run      = (state_q == ST_RUN);
    assign rd_sel   = sel_inc(sel_q);
    assign in_range = ({1'b0, wr_addr} < LLEN);
    assign transp   = (TRANSP != 0) && (wr_data[3:0] == 4'd0);
    assign wr_ok    = run && wr_we && in_range && !transp;
    assign rd_ok    = run && rd_stb;

    // Control next state: sweep progress, buffer rotation, overflow flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        ovf_d   = ovf_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else begin
            if (line_start) begin
                sel_d = rd_sel;
            end
            if (wr_we && !in_range) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Control registers with synchronous reset back into the sweep.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            ovf_q   <= ovf_d;
        end
    end

    // Read port: old value returned one cycle after the strobe, zero outside RUN.
    always_ff @(posedge clk) begin
        if (res || !run) begin
            rd_data_q <= '0;
        end else if (rd_stb) begin
            rd_data_q <= mem[idx(rd_sel, rd_addr)];
        end
    end

    // Storage: sweep clear in INIT; renderer write and display clear in RUN.
    // Write and clear always hit different buffers, so they never collide.
    always_ff @(posedge clk) begin
        if (!res) begin
            if (state_q == ST_INIT) begin
                mem[cnt_q[IW-1:0]] <= '0;
            end else begin
                if (wr_ok) begin
                    mem[idx(sel_q, wr_addr)] <= wr_data;
                end
                if (rd_ok) begin
                    mem[idx(rd_sel, rd_addr)] <= '0;
                end
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign init_busy = (state_q == ST_INIT);
    assign wr_ovf    = ovf_q;
    assign wr_sel    = sel_q;

endmodule

// File: tb/tb_video_linebuf.sv
// Directed testbench for video_linebuf: a default instance (two buffers)
// and a small three-buffer instance for the rotation sequence.
module tb_video_linebuf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance.
    logic       res0 = 1'b1, ls0 = 1'b0, we0 = 1'b0, rs0 = 1'b0;
    logic [8:0] wa0 = '0, ra0 = '0;
    logic [7:0] wd0 = '0, rd0;
    logic       busy0, ovf0;
    logic [1:0] sel0;

    video_linebuf u0 (
        .clk(clk), .res(res0), .line_start(ls0),
        .wr_addr(wa0), .wr_data(wd0), .wr_we(we0),
        .rd_addr(ra0), .rd_stb(rs0), .rd_data(rd0),
        .init_busy(busy0), .wr_ovf(ovf0), .wr_sel(sel0)
    );

    // Three-buffer instance with 16-entry buffers.
    logic       res1 = 1'b1, ls1 = 1'b0, we1 = 1'b0, rs1 = 1'b0;
    logic [3:0] wa1 = '0, ra1 = '0;
    logic [7:0] wd1 = '0, rd1;
    logic       busy1, ovf1;
    logic [1:0] sel1;

    video_linebuf #(.AW(4), .DW(8), .NBUF(3), .TRANSP(1), .LINE_LEN(16)) u1 (
        .clk(clk), .res(res1), .line_start(ls1),
        .wr_addr(wa1), .wr_data(wd1), .wr_we(we1),
        .rd_addr(ra1), .rd_stb(rs1), .rd_data(rd1),
        .init_busy(busy1), .wr_ovf(ovf1), .wr_sel(sel1)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr0(input logic [8:0] a, input logic [7:0] d, input logic with_ls);
        wa0 = a; wd0 = d; we0 = 1'b1; ls0 = with_ls;
        tick;
        we0 = 1'b0; ls0 = 1'b0;
    endtask

    task automatic rd0_chk(input string tag, input logic [8:0] a, input logic [7:0] exp);
        ra0 = a; rs0 = 1'b1;
        tick;
        rs0 = 1'b0;
        check(tag, rd0, exp);
    endtask

    task automatic ls0_chk(input string tag, input logic [1:0] exp_sel);
        ls0 = 1'b1;
        tick;
        ls0 = 1'b0;
        check(tag, sel0, exp_sel);
    endtask

    task automatic sweep0(output int cnt);
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 3000) begin
            tick;
            cnt++;
        end
    endtask

    task automatic sweep1(output int cnt);
        cnt = 0;
        while (busy1 === 1'b1 && cnt < 500) begin
            tick;
            cnt++;
        end
    endtask

    initial begin
        // Reset state of the default instance.
        tick;
        check("rst_rd_data", rd0, 8'h00);
        check("rst_busy", busy0, 1'b1);
        check("rst_ovf", ovf0, 1'b0);
        check("rst_sel", sel0, 2'd0);

        // Sweep with all RUN-only inputs active; they must be ignored.
        we0 = 1'b1; wa0 = 9'd10; wd0 = 8'h77; ls0 = 1'b1; rs0 = 1'b1; ra0 = 9'd10;
        res0 = 1'b0;
        sweep0(n);
        we0 = 1'b0; ls0 = 1'b0; rs0 = 1'b0;
        check("sweep_len", n, 1024);
        check("post_sweep_busy", busy0, 1'b0);
        check("post_sweep_sel", sel0, 2'd0);
        check("post_sweep_rd", rd0, 8'h00);
        check("post_sweep_ovf", ovf0, 1'b0);

        // Cleared contents; writes during the sweep left nothing behind.
        rd0_chk("clr_rd_b1", 9'd3, 8'h00);
        ls0_chk("ls_a", 2'd1);
        rd0_chk("init_wr_ignored", 9'd10, 8'h00);
        ls0_chk("ls_b", 2'd0);

        // Basic write, rotate, read-and-clear.
        wr0(9'd10, 8'h5A, 1'b0);
        ls0_chk("ls_c", 2'd1);
        rd0_chk("rd_5a", 9'd10, 8'h5A);
        tick;
        check("rd_hold", rd0, 8'h5A);
        rd0_chk("rd_cleared", 9'd10, 8'h00);

        // Transparency, write with line_start, read with line_start.
        wr0(9'd5, 8'h30, 1'b0);
        wr0(9'd6, 8'h31, 1'b0);
        wr0(9'd7, 8'h47, 1'b1);
        check("ls_with_wr_sel", sel0, 2'd0);
        rd0_chk("transp_suppressed", 9'd5, 8'h00);
        ra0 = 9'd6; rs0 = 1'b1; wa0 = 9'd6; wd0 = 8'h99; we0 = 1'b1;
        tick;
        rs0 = 1'b0; we0 = 1'b0;
        check("transp_nonzero", rd0, 8'h31);
        ra0 = 9'd7; rs0 = 1'b1; ls0 = 1'b1;
        tick;
        rs0 = 1'b0; ls0 = 1'b0;
        check("wr_pre_rotation", rd0, 8'h47);
        check("rd_ls_sel", sel0, 2'd1);
        ls0_chk("ls_d", 2'd0);
        rd0_chk("rd_ls_cleared", 9'd7, 8'h00);
        rd0_chk("rd_wr_cleared", 9'd6, 8'h00);
        ls0_chk("ls_e", 2'd1);
        rd0_chk("concurrent_wr", 9'd6, 8'h99);

        // Address range boundary and sticky overflow.
        wr0(9'd359, 8'hAB, 1'b0);
        check("ovf_at_359", ovf0, 1'b0);
        wr0(9'd360, 8'hAB, 1'b0);
        check("ovf_at_360", ovf0, 1'b1);
        wr0(9'd400, 8'hCD, 1'b0);
        ls0_chk("ovf_ls1_sel", 2'd0);
        check("ovf_ls1", ovf0, 1'b1);
        rd0_chk("ovf_no_wr_360", 9'd360, 8'h00);
        rd0_chk("ovf_no_wr_400", 9'd400, 8'h00);
        rd0_chk("wr_at_359", 9'd359, 8'hAB);
        ls0_chk("ovf_ls2_sel", 2'd1);
        check("ovf_ls2", ovf0, 1'b1);
        ls0_chk("ovf_ls3_sel", 2'd0);
        check("ovf_ls3", ovf0, 1'b1);

        // Reset during RUN.
        wr0(9'd20, 8'h5A, 1'b0);
        res0 = 1'b1;
        tick;
        check("run_rst_rd", rd0, 8'h00);
        check("run_rst_busy", busy0, 1'b1);
        check("run_rst_ovf", ovf0, 1'b0);
        check("run_rst_sel", sel0, 2'd0);
        res0 = 1'b0;

        // Reset during INIT restarts the full sweep.
        repeat (100) tick;
        check("mid_init_busy", busy0, 1'b1);
        res0 = 1'b1;
        tick;
        check("init_rst_busy", busy0, 1'b1);
        check("init_rst_sel", sel0, 2'd0);
        res0 = 1'b0;
        sweep0(n);
        check("resweep_len", n, 1024);
        ls0_chk("ls_f", 2'd1);
        rd0_chk("old_data_gone", 9'd20, 8'h00);

        // Three-buffer rotation.
        tick;
        check("u1_rst_busy", busy1, 1'b1);
        res1 = 1'b0;
        sweep1(n);
        check("u1_sweep_len", n, 48);
        check("u1_sel_l0", sel1, 2'd0);
        wa1 = 4'd0; wd1 = 8'h11; we1 = 1'b1; tick; we1 = 1'b0;
        ls1 = 1'b1; tick; ls1 = 1'b0;
        check("u1_sel_l1", sel1, 2'd1);
        wd1 = 8'h22; we1 = 1'b1; tick; we1 = 1'b0;
        ls1 = 1'b1; tick; ls1 = 1'b0;
        check("u1_sel_l2", sel1, 2'd2);
        wd1 = 8'h33; we1 = 1'b1; tick; we1 = 1'b0;
        ra1 = 4'd0; rs1 = 1'b1; tick; rs1 = 1'b0;
        check("u1_rd_l2", rd1, 8'h11);
        ls1 = 1'b1; tick; ls1 = 1'b0;
        check("u1_sel_l3", sel1, 2'd0);
        rs1 = 1'b1; tick; rs1 = 1'b0;
        check("u1_rd_l3", rd1, 8'h22);
        ls1 = 1'b1; tick; ls1 = 1'b0;
        check("u1_sel_l4", sel1, 2'd1);
        rs1 = 1'b1; tick; rs1 = 1'b0;
        check("u1_rd_l4", rd1, 8'h33);
        check("u1_ovf", ovf1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/video_linebuf.md
VIDEO_LINEBUF -- requirements
Module: video_linebuf

Interface
REQ-001 Parameter AW, default 9: pixel address width; each buffer holds 2^AW entries.
REQ-002 Parameter DW, default 8: pixel data width.
REQ-003 Parameter NBUF, default 2, legal range 2..4: number of rotating line buffers.
REQ-004 Parameter TRANSP, default 1: when 1, writes with wr_data[3:0]==0 are suppressed (transparent pixel).
REQ-005 Parameter LINE_LEN, default 360: highest legal write address plus one.
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 res  in  1  reset, synchronous, active-high.
REQ-008 line_start  in  1  one-cycle pulse; rotates buffer roles.
REQ-009 wr_addr  in  AW  renderer write address.
REQ-010 wr_data  in  DW  renderer write data.
REQ-011 wr_we  in  1  renderer write enable.
REQ-012 rd_addr  in  AW  display read address.
REQ-013 rd_stb  in  1  read-and-clear strobe.
REQ-014 rd_data  out  DW  registered read data.
REQ-015 init_busy  out  1  high while the power-up clear sweep runs.
REQ-016 wr_ovf  out  1  sticky flag for an out-of-range write.
REQ-017 wr_sel  out  2  index of the buffer currently being written.

Function
REQ-018 The FSM shall have two states, INIT and RUN; res forces INIT.
REQ-019 INIT: an internal counter of width AW+2 shall write 0 to every entry of every buffer, one entry per cycle, in NBUF*2^AW cycles.
- init_busy=1 throughout INIT.
- wr_we, rd_stb and line_start are ignored in INIT.
- rd_data is held at 0 in INIT.
REQ-020 INIT shall go to RUN on the cycle after the last entry is cleared; init_busy shall fall in that same cycle.
REQ-021 RUN: the write buffer is wr_sel; the read buffer is (wr_sel+1) mod NBUF, so display lags render by NBUF-1 lines.
REQ-022 On line_start in RUN, wr_sel shall advance to (wr_sel+1) mod NBUF, wrapping from NBUF-1 to 0.
REQ-023 wr_we in RUN shall write wr_data at wr_addr of the write buffer when all of the following hold:
- wr_addr < LINE_LEN;
- the write is not suppressed by REQ-004.
REQ-024 A write presented in the same cycle as line_start shall use the pre-rotation wr_sel.
REQ-025 rd_stb in RUN shall present the read-buffer entry at rd_addr on rd_data on the next cycle (latency 1).
- The same entry is written to 0 in the strobe cycle; the old value is returned (read-before-clear).
REQ-026 Without rd_stb, rd_data shall hold its previous value.
REQ-027 rd_stb in the same cycle as line_start shall read and clear the pre-rotation read buffer.
REQ-028 Write and read/clear paths shall target distinct buffers at all times, so no same-entry collision exists in RUN.
REQ-029 wr_we with wr_addr >= LINE_LEN in RUN:
- no write is performed;
- wr_ovf is set to 1 and stays 1 until res.
REQ-030 res asserted mid-INIT or mid-RUN shall restart the sweep from address 0, buffer 0.

Reset
REQ-031 On res the outputs shall take these values on the next edge:
- rd_data=0
- init_busy=1
- wr_ovf=0
- wr_sel=0
- FSM=INIT, sweep counter=0
REQ-032 Buffer contents are undefined until the sweep completes; after the sweep every entry reads 0.

Verification
REQ-033 Defaults; release res -> init_busy high exactly 1024 cycles, then 0; a read of any address returns 0.
REQ-034 Write 0x5A at address 10; line_start; rd_stb at address 10 -> rd_data=0x5A one cycle later; a second rd_stb at address 10 -> 0x00.
REQ-035 TRANSP=1, write 0x30 at address 5 -> suppressed; read after line_start returns 0; write 0x31 -> read returns 0x31.
REQ-036 wr_we at address 400 -> wr_ovf=1 and stays set through three line_starts; no entry is modified.
REQ-037 NBUF=3: write 0x11/0x22/0x33 at address 0 on lines 0/1/2 -> reads at address 0 return 0x11 on line 2, 0x22 on line 3, 0x33 on line 4; wr_sel sequence 0,1,2,0,1.
REQ-038 Pulse res during RUN and during INIT -> wr_sel=0, init_busy=1, the full sweep length is repeated, and earlier data reads 0.
